// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: two-port arbitrated sequencer for single 8-bit DRAM transfers over MAR/MDR.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req0/we0/addr0           core control unit request, direction (1=write), address
//   req1/we1/addr1           image load/store engine request, direction, address
//   ack0, ack1               one-cycle completion pulse to the granted requester
//   gnt                      one-hot grant {gnt1,gnt0}, valid ADDR through DONE
//   busy                     high whenever the sequencer is not idle
//   mar_addr, mar_load       latched transfer address and MAR load strobe
//   mdr_read, mdr_write      MDR capture strobes (DRAM data in / C_bus out)
//   dram_en, dram_we         DRAM enable and write enable
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mar_load,
  output logic              mdr_read,
  output logic              mdr_write,
  output logic              dram_en,
  output logic              dram_we
);
  typedef enum logic [2:0] {IDLE, ADDR, ACCESS, CAPTURE, DONE} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic              ptr_q, ptr_d;
  logic              win;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      port_q  <= port_d;
      ptr_q   <= ptr_d;
    end
  end
  // ptr_q=0 favours requester 0; a lone requester wins regardless of the pointer
  assign win = (req0 & req1) ? ptr_q : req1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req0 | req1) ? ADDR : IDLE;
      ADDR:    state_d = ACCESS;
      ACCESS:  state_d = (cnt_q != 4'd0) ? ACCESS : (we_q ? DONE : CAPTURE);
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    addr_d = addr_q;
    we_d   = we_q;
    port_d = port_q;
    ptr_d  = ptr_q;
    if (state_q == IDLE && (req0 | req1)) begin
      addr_d = win ? addr1 : addr0;
      we_d   = win ? we1 : we0;
      port_d = win;
      ptr_d  = ~win;
    end
    cnt_d = (state_q == ADDR) ? WAIT_INIT :
            (state_q == ACCESS && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    gnt       = busy ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    mar_addr  = addr_q;
    mar_load  = state_q == ADDR;
    mdr_write = (state_q == ADDR) & we_q;
    dram_en   = state_q == ACCESS;
    dram_we   = (state_q == ACCESS) & we_q;
    mdr_read  = state_q == CAPTURE;
    ack0      = (state_q == DONE) & ~port_q;
    ack1      = (state_q == DONE) & port_q;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with WAIT_CYCLES 2, 1 and 15 builds.
module tb_mem_access_ctrl;
  localparam int W = 2;
  typedef struct {int port; int addr; int we;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic ack0, ack1, busy, mar_load, mdr_read, mdr_write, dram_en, dram_we;
  logic [1:0] gnt;
  logic [15:0] mar_addr;
  logic r1 = 1'b0, r15 = 1'b0;
  logic a1_0, a1_1, b1, ml1, mr1, mw1, en1, dw1;
  logic a15_0, a15_1, b15, ml15, mr15, mw15, en15, dw15;
  logic [1:0] g1, g15;
  logic [15:0] ma1, ma15;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.ADDR_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .we0(we0), .addr0(addr0),
    .req1(req1), .we1(we1), .addr1(addr1), .ack0(ack0), .ack1(ack1), .gnt(gnt),
    .busy(busy), .mar_addr(mar_addr), .mar_load(mar_load), .mdr_read(mdr_read),
    .mdr_write(mdr_write), .dram_en(dram_en), .dram_we(dram_we));
  mem_access_ctrl #(.ADDR_W(16), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req0(r1), .we0(1'b0), .addr0(16'h0001),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .ack0(a1_0), .ack1(a1_1), .gnt(g1),
    .busy(b1), .mar_addr(ma1), .mar_load(ml1), .mdr_read(mr1),
    .mdr_write(mw1), .dram_en(en1), .dram_we(dw1));
  mem_access_ctrl #(.ADDR_W(16), .WAIT_CYCLES(15)) u15 (
    .clk(clk), .rst_n(rst_n), .req0(r15), .we0(1'b0), .addr0(16'h000F),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .ack0(a15_0), .ack1(a15_1), .gnt(g15),
    .busy(b15), .mar_addr(ma15), .mar_load(ml15), .mdr_read(mr15),
    .mdr_write(mw15), .dram_en(en15), .dram_we(dw15));
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: tracks each transfer from mar_load to ack and checks it against the queue head
  int cyc = 0, last_done = -10, start = 0, en_cnt = 0, rd_cnt = 0, cur_we = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
      rd_cnt = 0;
    end else begin
      int n;
      n = int'(mar_load) + int'(mdr_read) + int'(mdr_write) + int'(ack0) + int'(ack1);
      chk("strobe_excl", int'(n <= 1 || (n == 2 && mar_load && mdr_write)), 1);
      if (mar_load) begin
        chk("idle_gap", int'(cyc - last_done >= 2), 1);
        start = cyc; en_cnt = 0; rd_cnt = 0; cur_we = int'(mdr_write);
      end
      if (dram_en) begin
        en_cnt++;
        chk("dram_we", int'(dram_we), cur_we);
      end
      if (mdr_read) rd_cnt++;
      if (ack0 | ack1) begin
        if (q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_port", int'(ack1), e.port);
          chk("gnt", int'(gnt), e.port ? 2 : 1);
          chk("mar_addr", int'(mar_addr), e.addr);
          chk("we", cur_we, e.we);
          chk("dram_en_cycles", en_cnt, W);
          chk("mdr_read_cnt", rd_cnt, e.we ? 0 : 1);
          chk("latency", cyc - start, e.we ? W + 1 : W + 2);
        end
        last_done = cyc;
      end
      cyc++;
    end
  end
  task automatic wait_ack(input int p);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) return;
    end
    chk("ack_timeout", 0, 1);
  endtask
  task automatic wait_any(output int p);
    p = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        p = int'(ack1);
        return;
      end
    end
    chk("ack_timeout", 0, 1);
  endtask
  task automatic check_idle_outs(input string name);
    chk(name, int'({ack0, ack1, gnt, busy, mar_load, mdr_read, mdr_write, dram_en, dram_we}), 0);
    chk({name, "_mar"}, int'(mar_addr), 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_outs("async_reset");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int p, n, t1, t15, c1, c15;
    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    #1 rst_n = 1'b1;
    // read on port 0
    @(negedge clk);
    q.push_back('{0, 'h1234, 0});
    req0 = 1; we0 = 0; addr0 = 16'h1234;
    wait_ack(0);
    req0 = 0;
    // write on port 1
    @(negedge clk);
    q.push_back('{1, 'h00FF, 1});
    req1 = 1; we1 = 1; addr1 = 16'h00FF;
    wait_ack(1);
    req1 = 0;
    // both held: after reset port 0 first, then alternation
    pulse_reset();
    q.push_back('{0, 'hA000, 0});
    q.push_back('{1, 'hB000, 1});
    q.push_back('{0, 'hA000, 0});
    q.push_back('{1, 'hB000, 1});
    addr0 = 16'hA000; we0 = 0; addr1 = 16'hB000; we1 = 1;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_any(p);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end else begin
        if (p == 1) req1 = 0; else req0 = 0;
        @(negedge clk);
        if (p == 1) req1 = 1; else req0 = 1;
      end
    end
    // reset during ACCESS of a read aborts; restart afterwards
    repeat (2) @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 16'h0ABC;
    n = 0;
    while (!dram_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_access", int'(dram_en), 1);
    pulse_reset();
    q.push_back('{0, 'h0ABC, 0});
    wait_ack(0);
    req0 = 0;
    // req0 dropped after grant, addr/we perturbed; req1 pending is served next
    @(negedge clk);
    q.push_back('{0, 'h0055, 0});
    q.push_back('{1, 'h1111, 0});
    req0 = 1; we0 = 0; addr0 = 16'h0055;
    @(negedge clk);
    req0 = 0; we0 = 1; addr0 = 16'hFFFF;
    req1 = 1; we1 = 0; addr1 = 16'h1111;
    wait_ack(0);
    wait_ack(1);
    req1 = 0;
    // WAIT_CYCLES=1 and 15 builds: dram_en length and read ack cycle
    repeat (2) @(negedge clk);
    r1 = 1; r15 = 1;
    t1 = -1; t15 = -1; c1 = 0; c15 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (en1) c1++;
      if (en15) c15++;
      if (a1_0) begin t1 = i; r1 = 0; end
      if (a15_0) begin t15 = i; r15 = 0; end
    end
    chk("w1_en_cycles", c1, 1);
    chk("w1_ack_cycle", t1, 4);
    chk("w15_en_cycles", c15, 15);
    chk("w15_ack_cycle", t15, 18);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences single 8-bit DRAM transfers through the MAR/MDR path of the downsampling processor.
- Arbitrates between two requesters: port 0 is the core control unit, port 1 is the image load/store engine.
- Drives MAR load, the MDR read/write strobes and the DRAM enable/write-enable with a programmable number of wait states.
- Returns a one-cycle acknowledge to whichever requester was granted.

Parameters:
ADDR_W, 16, DRAM address width.
WAIT_CYCLES, 2, cycles dram_en is held per access; legal range 1..15 (4-bit counter).

Ports:
clk  in  1  system clock, all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
req0  in  1  requester 0 transfer request, level, held until ack0.
we0  in  1  requester 0 direction, 1=write, 0=read.
addr0  in  ADDR_W  requester 0 address.
req1  in  1  requester 1 transfer request.
we1  in  1  requester 1 direction.
addr1  in  ADDR_W  requester 1 address.
ack0  out  1  one-cycle transfer-complete pulse to requester 0.
ack1  out  1  one-cycle transfer-complete pulse to requester 1.
gnt  out  2  one-hot grant, {gnt1,gnt0}.
busy  out  1  high whenever state != IDLE.
mar_addr  out  ADDR_W  latched address of the granted transfer.
mar_load  out  1  MAR load strobe.
mdr_read  out  1  MDR strobe: capture DRAM data.
mdr_write  out  1  MDR strobe: capture C_bus into the DRAM-side data register.
dram_en  out  1  DRAM access enable.
dram_we  out  1  DRAM write enable, valid while dram_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, wait counter=0, latched addr=0, latched we=0.
  - Round-robin pointer favours requester 0.
  - All outputs 0.
  - Reset mid-transfer aborts immediately with no ack and no strobes.
- Outputs are Moore decodes of registered state plus latched fields; no combinational path from req inputs to outputs.
- IDLE:
  - If any req is high, grant, latch addr/we of the winner, set gnt, go to ADDR.
  - Arbitration when both req are high: grant the requester the pointer favours. The pointer then favours the other requester.
  - A single requester always wins regardless of pointer; the pointer still flips away from it.
- ADDR (1 cycle): mar_load=1; mar_addr=latched addr; mdr_write=latched we. Load wait counter with WAIT_CYCLES-1. Go to ACCESS.
- ACCESS (WAIT_CYCLES cycles): dram_en=1; dram_we=latched we. Counter decrements each cycle. When the counter is 0, go to CAPTURE if reading, else DONE.
- CAPTURE (read only, 1 cycle): mdr_read=1. Go to DONE.
- DONE (1 cycle): ack of the granted port=1. gnt stays valid from ADDR through DONE and clears on return to IDLE.
- Latency with req sampled in IDLE at cycle 0:
  - Read: ack at cycle 3+WAIT_CYCLES; MDR holds the read data from that same cycle.
  - Write: ack at cycle 2+WAIT_CYCLES.
- Back-to-back transfers: minimum one IDLE cycle between DONE and the next ADDR. The requester must drop req on the edge ending DONE, otherwise a new transfer starts.
- Requests:
  - req deasserted after grant is ignored; the transfer completes and ack still pulses.
  - addr/we changes after grant have no effect.
  - The non-granted requester's req is held pending, never lost.
- mar_addr holds its last value in IDLE and updates only on grant.
- Never more than one of mar_load/mdr_read/mdr_write/ack active in a single cycle, except mar_load with mdr_write in ADDR.

Test Plan:
- Reset, then req0=1, we0=0, addr0=0x1234, WAIT_CYCLES=2.
  -> Cycle 1: mar_load=1, mar_addr=0x1234.
  -> Cycles 2-3: dram_en=1, dram_we=0.
  -> Cycle 4: mdr_read=1.
  -> Cycle 5: ack0=1, gnt=01.
- req1=1, we1=1, addr1=0x00FF.
  -> Cycle 1: mar_load=1 and mdr_write=1.
  -> Cycles 2-3: dram_en=1, dram_we=1.
  -> Cycle 4: ack1=1; mdr_read never asserts.
- req0 and req1 held high continuously, each dropping for one cycle after its ack.
  -> Grants alternate 0,1,0,1.
  -> Pointer after reset gives the first grant to port 0.
- rst_n pulsed low during ACCESS of a read.
  -> All outputs 0 asynchronously, no ack.
  -> After release with req0 still high, a fresh transfer restarts from ADDR.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds.
  -> dram_en asserts for exactly 1 and 15 cycles respectively.
  -> Read ack at cycles 4 and 18.
- req0 dropped one cycle after grant.
  -> Transfer completes and ack0 pulses.
  -> A req1 raised during the transfer is granted in the next ADDR after one IDLE cycle.
